// File: rtl/data_mem_access_unit.sv
// Purpose: serialises aligned 1/2/4-byte core loads/stores into byte cycles on a byte-wide synchronous SRAM.
// Latency: store N+1 cycles, load N+MEM_RD_LAT+1 cycles from request to DONE (N = access bytes).
// Backpressure: stall held high from the request cycle through the last transfer; low in DONE and IDLE.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_read_en/req_write_en      load/store request, held by the core while stall=1
//   req_size                      funct3 size code (B, H, W, BU, HU)
//   req_addr, req_wdata           byte address and store data
//   stall                         pipeline freeze to the core
//   rdata, rdata_valid            extended load result and its one-cycle qualifier
//   access_err                    one-cycle pulse for an illegal request
//   mem_addr/mem_wdata/mem_we/mem_re/mem_rdata   byte-wide SRAM interface
module data_mem_access_unit #(
  parameter int ADDR_W     = 10,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_read_en,
  input  logic              req_write_en,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              access_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_W-1:0]     r_addr;
  logic [31:0]           r_wdata;
  logic [2:0]            r_size;
  logic                  r_write;
  logic [2:0]            r_n;       // bytes in this access: 1, 2 or 4
  logic [2:0]            r_i;       // bytes issued
  logic [2:0]            r_j;       // bytes captured (loads)
  logic [31:0]           r_buf;
  logic [31:0]           r_rdata;
  logic [MEM_RD_LAT-1:0] r_vpipe;   // read-valid delay line, one stage per SRAM latency cycle

  logic                  w_req;
  logic                  w_illegal;
  logic                  w_accept;
  logic                  w_cap;
  logic [31:0]           w_buf_next;
  logic                  w_unused_addr_hi;

  // Address bits above ADDR_W are dropped by design.
  assign w_unused_addr_hi = ^req_addr[31:ADDR_W];

  assign w_req = req_read_en | req_write_en;

  assign w_illegal = (req_read_en & req_write_en)
                   | (req_size[1:0] == 2'b11)
                   | (req_write_en & req_size[2])
                   | (req_size[2] & ~req_read_en)
                   | ((req_size[1:0] == 2'b01) & req_addr[0])
                   | ((req_size[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));

  // A captured byte arrives when the oldest stage of the delay line fires.
  assign w_cap = r_vpipe[MEM_RD_LAT-1] & (r_state == S_XFER) & ~r_write;

  assign rdata       = r_rdata;
  assign rdata_valid = (r_state == S_DONE) & ~r_write;

  function automatic logic [31:0] extend(input logic [31:0] b, input logic [2:0] sz);
    logic [31:0] res;
    case (sz[1:0])
      2'b00:   res = {{24{b[7]  & ~sz[2]}}, b[7:0]};
      2'b01:   res = {{16{b[15] & ~sz[2]}}, b[15:0]};
      default: res = b;
    endcase
    return res;
  endfunction

  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[{r_j[1:0], 3'b000} +: 8] = mem_rdata;
  end

  always_comb begin
    w_next     = r_state;
    stall      = 1'b0;
    access_err = 1'b0;
    w_accept   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // rst_n gating keeps stall/access_err low while reset is asserted.
        if (rst_n && w_req) begin
          if (w_illegal) begin
            access_err = 1'b1;
          end else begin
            stall    = 1'b1;
            w_accept = 1'b1;
            w_next   = S_XFER;
          end
        end
      end
      S_XFER: begin
        stall    = rst_n;
        mem_addr = r_addr + ADDR_W'(r_i);
        if (r_write) begin
          mem_we    = 1'b1;
          mem_wdata = r_wdata[{r_i[1:0], 3'b000} +: 8];
          if (r_i == r_n - 3'd1) w_next = S_DONE;
        end else begin
          // Issue phase ends at byte N-1; then wait for the delay line to drain.
          mem_re = (r_i < r_n);
          if (w_cap && (r_j == r_n - 3'd1)) w_next = S_DONE;
        end
      end
      S_DONE: begin
        // The core still presents the finished request here, so inputs are ignored.
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_write <= 1'b0;
      r_n     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_buf   <= '0;
      r_rdata <= '0;
      r_vpipe <= '0;
    end else begin
      r_state    <= w_next;
      r_vpipe[0] <= mem_re;
      for (int k = 1; k < MEM_RD_LAT; k++) begin
        r_vpipe[k] <= r_vpipe[k-1];
      end
      if (w_accept) begin
        r_addr  <= req_addr[ADDR_W-1:0];
        r_wdata <= req_wdata;
        r_size  <= req_size;
        r_write <= req_write_en;
        r_n     <= 3'd1 << req_size[1:0];
        r_i     <= '0;
        r_j     <= '0;
      end else if (r_state == S_XFER) begin
        if (mem_we || mem_re) r_i <= r_i + 3'd1;
        if (w_cap) begin
          r_buf <= w_buf_next;
          r_j   <= r_j + 3'd1;
          if (r_j == r_n - 3'd1) r_rdata <= extend(w_buf_next, r_size);
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
module tb_data_mem_access_unit;

  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          re_i[2];
  logic          we_i[2];
  logic [2:0]    size_i[2];
  logic [31:0]   addr_i[2];
  logic [31:0]   wdata_i[2];
  logic          stall_o[2];
  logic          rv_o[2];
  logic          err_o[2];
  logic          mwe_o[2];
  logic          mre_o[2];
  logic [31:0]   rdata_o[2];
  logic [AW-1:0] maddr_o[2];
  logic [7:0]    mwd_o[2];
  logic [7:0]    mrd_i[2];

  data_mem_access_unit #(.ADDR_W(AW), .MEM_RD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .req_read_en(re_i[0]), .req_write_en(we_i[0]), .req_size(size_i[0]),
    .req_addr(addr_i[0]), .req_wdata(wdata_i[0]),
    .stall(stall_o[0]), .rdata(rdata_o[0]), .rdata_valid(rv_o[0]), .access_err(err_o[0]),
    .mem_addr(maddr_o[0]), .mem_wdata(mwd_o[0]), .mem_we(mwe_o[0]), .mem_re(mre_o[0]),
    .mem_rdata(mrd_i[0]));

  data_mem_access_unit #(.ADDR_W(AW), .MEM_RD_LAT(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n),
    .req_read_en(re_i[1]), .req_write_en(we_i[1]), .req_size(size_i[1]),
    .req_addr(addr_i[1]), .req_wdata(wdata_i[1]),
    .stall(stall_o[1]), .rdata(rdata_o[1]), .rdata_valid(rv_o[1]), .access_err(err_o[1]),
    .mem_addr(maddr_o[1]), .mem_wdata(mwd_o[1]), .mem_we(mwe_o[1]), .mem_re(mre_o[1]),
    .mem_rdata(mrd_i[1]));

  // Byte SRAMs driven by the DUTs, plus a transaction-level model memory.
  logic [7:0] sram[2][1024];
  logic [7:0] model_mem[2][1024];
  logic [7:0] rp[2][3];
  bit         mem_init_done;

  function automatic logic [7:0] init_byte(input int k, input int a);
    return 8'((a * 37 + k * 11 + 5) ^ (a >> 3));
  endfunction

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int k = 0; k < 2; k++)
        for (int a = 0; a < 1024; a++) sram[k][a] = init_byte(k, a);
      mem_init_done = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (mwe_o[k]) sram[k][maddr_o[k]] = mwd_o[k];
      rp[k][0] <= mre_o[k] ? sram[k][maddr_o[k]] : 8'($urandom);
      rp[k][1] <= rp[k][0];
      rp[k][2] <= rp[k][1];
    end
  end

  assign mrd_i[0] = rp[0][0];
  assign mrd_i[1] = rp[1][2];

  int we_tot[2];
  int re_tot[2];
  int viol;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mwe_o[k]) we_tot[k] = we_tot[k] + 1;
      if (mre_o[k]) re_tot[k] = re_tot[k] + 1;
      if ((mwe_o[k] && mre_o[k]) || ((mwe_o[k] || mre_o[k]) && !stall_o[k])) viol = viol + 1;
    end
  end

  int          total;
  int          bad;
  logic [31:0] last_rd[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic bit model_legal(input bit re, input bit we, input bit [2:0] sz, input bit [31:0] a);
    int n;
    if (re == we) return 1'b0;
    if (sz[1:0] == 2'b11) return 1'b0;
    if (we && sz[2]) return 1'b0;
    n = 1 << sz[1:0];
    return (a % n) == 0;
  endfunction

  // Little-endian gather, then sign/zero extension by plain arithmetic.
  function automatic logic [31:0] model_load(input int k, input bit [2:0] sz, input bit [31:0] a);
    longint v;
    int     n;
    n = 1 << sz[1:0];
    v = 0;
    for (int m = n - 1; m >= 0; m--) v = v * 256 + longint'(model_mem[k][(a + m) % 1024]);
    if (!sz[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // Starts at posedge+1; holds the request until the first stall=0 cycle, then drops it.
  task automatic do_req(input int k, input bit re, input bit we, input bit [2:0] sz,
                        input bit [31:0] a, input bit [31:0] wd, input string tag,
                        output bit got_err, output logic [31:0] got_rd);
    bit          legal;
    bit          seq_ok;
    int          n, l, exp_lat, done, we0, re0;
    l     = (k == 0) ? 1 : 3;
    legal = model_legal(re, we, sz, a);
    n     = 1 << sz[1:0];
    if (legal && re) last_rd[k] = model_load(k, sz, a);
    exp_lat    = !legal ? 0 : (we ? n + 1 : n + l + 1);
    re_i[k]    = re;
    we_i[k]    = we;
    size_i[k]  = sz;
    addr_i[k]  = a;
    wdata_i[k] = wd;
    we0 = we_tot[k];
    re0 = re_tot[k];
    seq_ok  = 1'b1;
    done    = -1;
    got_err = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        got_err = err_o[k];
        check({tag, " access_err"}, 32'(err_o[k]), 32'(!legal));
      end
      if (legal && c >= 1 && c <= n) begin
        if (maddr_o[k] != AW'((a + 32'(c) - 32'd1) % 1024)) seq_ok = 1'b0;
        if (we) begin
          if (!mwe_o[k] || mre_o[k] || mwd_o[k] != wd[8*(c-1) +: 8]) seq_ok = 1'b0;
        end else if (!mre_o[k] || mwe_o[k]) begin
          seq_ok = 1'b0;
        end
      end
      if (!stall_o[k]) begin
        done = c;
        break;
      end
    end
    got_rd = rdata_o[k];
    check({tag, " done_cycle"}, 32'(done), 32'(exp_lat));
    check({tag, " rdata_valid"}, 32'(rv_o[k]), 32'(legal && re));
    check({tag, " rdata"}, rdata_o[k], last_rd[k]);
    check({tag, " strobe_seq"}, 32'(seq_ok), 32'd1);
    check({tag, " strobe_count"}, 32'((we_tot[k] - we0) + (re_tot[k] - re0)), 32'(legal ? n : 0));
    if (legal && we)
      for (int m = 0; m < n; m++) model_mem[k][(a + 32'(m)) % 1024] = wd[8*m +: 8];
    @(posedge clk);
    #1;
    re_i[k] = 1'b0;
    we_i[k] = 1'b0;
  endtask

  typedef struct {
    bit        re;
    bit        we;
    bit [2:0]  sz;
    bit [31:0] a;
    bit [31:0] wd;
    bit        err;
    bit [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit          ge;
    logic [31:0] gr;
    logic [7:0]  orig22, orig23;
    bit          re, we;
    bit [2:0]    sz;
    bit [31:0]   a, wd;
    int          r, p, mism;

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      re_i[k] = 0; we_i[k] = 0; size_i[k] = 0; addr_i[k] = 0; wdata_i[k] = 0;
      last_rd[k] = 0;
      for (int x = 0; x < 1024; x++) model_mem[k][x] = init_byte(k, x);
    end
    re_i[0]   = 1'b1;
    size_i[0] = 3'b010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset ctl_outs", 32'({stall_o[k], rv_o[k], err_o[k], mwe_o[k], mre_o[k], maddr_o[k], mwd_o[k]}), 32'd0);
      check("reset rdata", rdata_o[k], 32'd0);
    end
    re_i[0] = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors on the MEM_RD_LAT=1 instance.
    tbl.push_back('{0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0});
    tbl.push_back('{1, 0, 3'b000, 32'h13, 32'h0, 0, 32'hFFFFFFDE});
    tbl.push_back('{1, 0, 3'b100, 32'h13, 32'h0, 0, 32'h000000DE});
    tbl.push_back('{1, 0, 3'b001, 32'h12, 32'h0, 0, 32'hFFFFDEAD});
    tbl.push_back('{1, 0, 3'b101, 32'h12, 32'h0, 0, 32'h0000DEAD});
    tbl.push_back('{1, 0, 3'b000, 32'h10, 32'h0, 0, 32'hFFFFFFEF});
    tbl.push_back('{1, 0, 3'b001, 32'h10, 32'h0, 0, 32'hFFFFBEEF});
    tbl.push_back('{1, 0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF});
    tbl.push_back('{1, 0, 3'b010, 32'h11, 32'h0, 1, 32'h0});
    tbl.push_back('{0, 1, 3'b001, 32'h13, 32'h1234, 1, 32'h0});
    tbl.push_back('{1, 1, 3'b010, 32'h10, 32'h0, 1, 32'h0});
    tbl.push_back('{1, 0, 3'b011, 32'h10, 32'h0, 1, 32'h0});
    tbl.push_back('{0, 1, 3'b100, 32'h10, 32'h55, 1, 32'h0});
    tbl.push_back('{1, 0, 3'b101, 32'h11, 32'h0, 1, 32'h0});
    tbl.push_back('{0, 1, 3'b000, 32'hFFFFFC10, 32'h7F, 0, 32'h0});
    tbl.push_back('{1, 0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBE7F});
    foreach (tbl[i]) begin
      do_req(0, tbl[i].re, tbl[i].we, tbl[i].sz, tbl[i].a, tbl[i].wd, "tbl", ge, gr);
      check("tbl err_vec", 32'(ge), 32'(tbl[i].err));
      if (tbl[i].re && !tbl[i].err) check("tbl rdata_vec", gr, tbl[i].rd);
    end

    // Reset in the middle of a store: two bytes land, nothing after.
    orig22 = model_mem[0][10'h22];
    orig23 = model_mem[0][10'h23];
    we_i[0] = 1'b1; size_i[0] = 3'b010; addr_i[0] = 32'h20; wdata_i[0] = 32'h11223344;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst ctl_outs", 32'({stall_o[0], rv_o[0], err_o[0], mwe_o[0], mre_o[0], maddr_o[0], mwd_o[0]}), 32'd0);
    check("midrst rdata", rdata_o[0], 32'd0);
    check("midrst bytes", {sram[0][10'h20], sram[0][10'h21], sram[0][10'h22], sram[0][10'h23]},
          {8'h44, 8'h33, orig22, orig23});
    model_mem[0][10'h20] = 8'h44;
    model_mem[0][10'h21] = 8'h33;
    last_rd[0] = 0;
    last_rd[1] = 0;
    we_i[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_req(0, 1, 0, 3'b010, 32'h20, 32'h0, "post_rst lw", ge, gr);
    check("post_rst low_half", 32'(gr[15:0]), 32'h3344);

    // MEM_RD_LAT=3 instance: long load, then back-to-back store and load.
    do_req(1, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, "l3 sw", ge, gr);
    do_req(1, 1, 0, 3'b010, 32'h10, 32'h0, "l3 lw", ge, gr);
    check("l3 lw value", gr, 32'hDEADBEEF);
    do_req(1, 0, 1, 3'b010, 32'h14, 32'h11223344, "l3 sw2", ge, gr);
    do_req(1, 1, 0, 3'b001, 32'h16, 32'h0, "l3 lh", ge, gr);
    check("l3 lh value", gr, 32'h00001122);

    // Random traffic against the model on both latencies.
    for (int k = 0; k < 2; k++) begin
      for (int it = 0; it < 150; it++) begin
        r = $urandom_range(0, 9);
        re = (r < 5);
        we = (r == 0) || (r >= 5);
        if ($urandom_range(0, 4) == 0) begin
          sz = 3'($urandom);
        end else begin
          p = $urandom_range(0, re ? 4 : 2);
          case (p)
            0: sz = 3'b000;
            1: sz = 3'b001;
            2: sz = 3'b010;
            3: sz = 3'b100;
            default: sz = 3'b101;
          endcase
        end
        a = $urandom & 32'hFFFFFC3F;
        if ($urandom_range(0, 5) != 0) a = a & ~((32'd1 << sz[1:0]) - 32'd1);
        wd = $urandom;
        do_req(k, re, we, sz, a, wd, "rnd", ge, gr);
      end
    end

    for (int k = 0; k < 2; k++) begin
      mism = 0;
      for (int x = 0; x < 1024; x++) if (sram[k][x] !== model_mem[k][x]) mism++;
      check("memory image", 32'(mism), 32'd0);
    end
    check("strobe rule", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
